// File: rtl/control_t_arb.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | control_t_arb : packet-atomic N-channel arbiter onto a single lp stream,  |
// |                 with cancel, max-length flush and a stray/drop counter.   |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module control_t_arb #(
   parameter int NUM_CH  = 2,
   parameter int DATA_W  = 8,
   parameter int RR_MODE = 0,
   parameter int MAX_LEN = 1027
) (
   input  logic                     i_control_t_arb_clk,
   input  logic                     i_control_t_arb_rst,
   input  logic                     i_control_t_arb_en,
   input  logic [NUM_CH-1:0]        i_control_t_arb_src_sop,
   input  logic [NUM_CH-1:0]        i_control_t_arb_src_eop,
   input  logic [NUM_CH-1:0]        i_control_t_arb_src_valid,
   input  logic [NUM_CH*DATA_W-1:0] i_control_t_arb_src_data,
   input  logic [NUM_CH-1:0]        i_control_t_arb_src_cancle,
   output logic [NUM_CH-1:0]        o_control_t_arb_src_ready,
   input  logic                     i_control_t_arb_lp_ready,
   output logic                     o_control_t_arb_lp_sop,
   output logic                     o_control_t_arb_lp_eop,
   output logic                     o_control_t_arb_lp_valid,
   output logic [DATA_W-1:0]        o_control_t_arb_lp_data,
   output logic                     o_control_t_arb_lp_cancle,
   output logic                     o_control_t_arb_lp_eop_en,
   output logic [NUM_CH-1:0]        o_control_t_arb_grant,
   output logic                     o_control_t_arb_busy,
   output logic [7:0]               o_control_t_arb_drop_cnt
);
   localparam int C_PTR_W = $clog2(NUM_CH);
   localparam int C_CNT_W = $clog2(MAX_LEN + 1);
   localparam logic [C_CNT_W-1:0] C_MAX_LEN = C_CNT_W'(MAX_LEN);
   localparam logic [C_PTR_W-1:0] C_LAST_CH = C_PTR_W'(NUM_CH - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_PKT   = 2'd1,
      S_FLUSH = 2'd2
   } state_t;

   state_t               state_q;
   logic [NUM_CH-1:0]    grant_q;
   logic [C_PTR_W-1:0]   gidx_q;
   logic [C_PTR_W-1:0]   ptr_q;
   logic [C_CNT_W-1:0]   cnt_q;
   logic                 lp_valid_q;
   logic                 lp_sop_q;
   logic                 lp_eop_q;
   logic [DATA_W-1:0]    lp_data_q;
   logic                 lp_cancle_q;
   logic [7:0]           drop_cnt_q;

   logic                 w_in_ready;
   logic [NUM_CH-1:0]    w_cand;
   logic [NUM_CH-1:0]    w_stray;
   logic [2*NUM_CH-1:0]  w_cand_rot;
   logic                 w_win_found;
   logic [C_PTR_W-1:0]   w_win_idx;
   logic [C_PTR_W-1:0]   w_win_nxt;
   logic [NUM_CH-1:0]    w_win_onehot;
   logic [C_PTR_W-1:0]   w_sel;
   logic                 w_sel_valid;
   logic                 w_sel_eop;
   logic                 w_sel_cancle;
   logic [DATA_W-1:0]    w_sel_data;
   logic [NUM_CH-1:0]    w_ready;
   logic [C_CNT_W-1:0]   w_cnt_nxt;
   logic                 w_overflow;
   logic                 w_drop_evt;

   assign w_in_ready = ~lp_valid_q | i_control_t_arb_lp_ready;
   assign w_cand     = i_control_t_arb_src_valid & i_control_t_arb_src_sop
                       & {NUM_CH{i_control_t_arb_en}};
   assign w_stray    = i_control_t_arb_src_valid & ~i_control_t_arb_src_sop;

   // Rotating the candidate vector by the pointer turns round-robin into a
   // lowest-set-bit search; fixed mode simply uses a zero rotation.
   assign w_cand_rot = {w_cand, w_cand} >> ((RR_MODE != 0) ? ptr_q : '0);

   always_comb begin
      int v_idx;
      w_win_found = 1'b0;
      v_idx       = 0;
      for (int off = NUM_CH - 1; off >= 0; off--) begin
         if (w_cand_rot[off]) begin
            w_win_found = 1'b1;
            v_idx       = ((RR_MODE != 0) ? int'(ptr_q) : 0) + off;
         end
      end
      if (v_idx >= NUM_CH) begin
         v_idx = v_idx - NUM_CH;
      end
      w_win_idx = C_PTR_W'(v_idx);
   end

   assign w_win_nxt = (w_win_idx == C_LAST_CH) ? '0 : w_win_idx + 1'b1;
   assign w_sel     = (state_q == S_IDLE) ? w_win_idx : gidx_q;

   always_comb begin
      w_sel_valid  = 1'b0;
      w_sel_eop    = 1'b0;
      w_sel_cancle = 1'b0;
      w_sel_data   = '0;
      w_win_onehot = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         w_win_onehot[k] = (w_win_idx == C_PTR_W'(k));
         if (w_sel == C_PTR_W'(k)) begin
            w_sel_valid  = i_control_t_arb_src_valid[k];
            w_sel_eop    = i_control_t_arb_src_eop[k];
            w_sel_cancle = i_control_t_arb_src_cancle[k];
            w_sel_data   = i_control_t_arb_src_data[k*DATA_W +: DATA_W];
         end
      end
   end

   always_comb begin
      w_ready = '0;
      case (state_q)
         S_IDLE: begin
            w_ready = w_stray;
            if (w_win_found) begin
               w_ready[w_win_idx] = w_in_ready;
            end
         end
         S_PKT:   w_ready[gidx_q] = w_in_ready;
         S_FLUSH: w_ready[gidx_q] = 1'b1;
         default: w_ready = '0;
      endcase
      if (i_control_t_arb_rst) begin
         w_ready = '0;
      end
   end

   assign w_cnt_nxt  = cnt_q + 1'b1;
   assign w_overflow = (state_q == S_PKT) & ~w_sel_cancle & w_sel_valid & w_in_ready
                       & ~w_sel_eop & (w_cnt_nxt == C_MAX_LEN);
   assign w_drop_evt = ((state_q == S_IDLE) & (|w_stray)) | w_overflow;

   always_ff @(posedge i_control_t_arb_clk) begin
      if (i_control_t_arb_rst) begin
         state_q     <= S_IDLE;
         grant_q     <= '0;
         gidx_q      <= '0;
         ptr_q       <= '0;
         cnt_q       <= '0;
         lp_valid_q  <= 1'b0;
         lp_sop_q    <= 1'b0;
         lp_eop_q    <= 1'b0;
         lp_data_q   <= '0;
         lp_cancle_q <= 1'b0;
         drop_cnt_q  <= '0;
      end else begin
         lp_cancle_q <= 1'b0;
         if (w_in_ready) begin
            lp_valid_q <= 1'b0;
         end
         if (w_drop_evt && (drop_cnt_q != 8'hFF)) begin
            drop_cnt_q <= drop_cnt_q + 1'b1;
         end
         case (state_q)
            S_IDLE: begin
               if (w_win_found && w_in_ready) begin
                  lp_valid_q <= 1'b1;
                  lp_sop_q   <= 1'b1;
                  lp_eop_q   <= w_sel_eop;
                  lp_data_q  <= w_sel_data;
                  ptr_q      <= w_win_nxt;
                  if (!w_sel_eop) begin
                     state_q <= S_PKT;
                     grant_q <= w_win_onehot;
                     gidx_q  <= w_win_idx;
                     cnt_q   <= C_CNT_W'(1);
                  end
               end
            end
            S_PKT: begin
               if (w_sel_cancle) begin
                  lp_cancle_q <= 1'b1;
                  lp_valid_q  <= 1'b0;
                  state_q     <= S_IDLE;
                  grant_q     <= '0;
               end else if (w_sel_valid && w_in_ready) begin
                  cnt_q <= w_cnt_nxt;
                  if (w_overflow) begin
                     lp_cancle_q <= 1'b1;
                     state_q     <= S_FLUSH;
                  end else begin
                     lp_valid_q <= 1'b1;
                     lp_sop_q   <= 1'b0;
                     lp_eop_q   <= w_sel_eop;
                     lp_data_q  <= w_sel_data;
                     if (w_sel_eop) begin
                        state_q <= S_IDLE;
                        grant_q <= '0;
                     end
                  end
               end
            end
            S_FLUSH: begin
               if (w_sel_cancle) begin
                  lp_cancle_q <= 1'b1;
                  lp_valid_q  <= 1'b0;
                  state_q     <= S_IDLE;
                  grant_q     <= '0;
               end else if (w_sel_valid && w_sel_eop) begin
                  state_q <= S_IDLE;
                  grant_q <= '0;
               end
            end
            default: begin
               state_q <= S_IDLE;
               grant_q <= '0;
            end
         endcase
      end
   end

   assign o_control_t_arb_src_ready = w_ready;
   assign o_control_t_arb_lp_sop    = lp_sop_q;
   assign o_control_t_arb_lp_eop    = lp_eop_q;
   assign o_control_t_arb_lp_valid  = lp_valid_q;
   assign o_control_t_arb_lp_data   = lp_data_q;
   assign o_control_t_arb_lp_cancle = lp_cancle_q;
   assign o_control_t_arb_lp_eop_en = lp_valid_q & lp_eop_q & i_control_t_arb_lp_ready;
   assign o_control_t_arb_grant     = grant_q;
   assign o_control_t_arb_busy      = (state_q != S_IDLE);
   assign o_control_t_arb_drop_cnt  = drop_cnt_q;
endmodule
`default_nettype wire
